// File: rtl/mario_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mario_pkg
//  Description : Shared definitions between mario_event_gen and state_fsm:
//                the game-state encoding, its typedef and the default
//                per-level constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package mario_pkg;

  // Game state as driven by state_fsm.
  typedef logic [1:0] game_state_t;

  localparam game_state_t ST_IDLE = 2'b00;
  localparam game_state_t ST_PLAY = 2'b01;
  localparam game_state_t ST_OVER = 2'b10;
  localparam game_state_t ST_WIN  = 2'b11;

  // Default per-level settings.
  localparam int DEF_LIVES_INIT   = 3;
  localparam int DEF_TIME_W       = 9;
  localparam int DEF_TIME_INIT    = 300;
  localparam int DEF_INVULN_TICKS = 60;

  // True while the game is actively being played.
  function automatic logic is_play(input game_state_t s);
    return (s == ST_PLAY);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tick_down_counter
//  Description : Loadable, tick-enabled, saturating down-counter. The zero
//                flag is registered alongside the value so that both leave
//                the block straight from flops.
//  Ports       : clk        - system clock
//                rst        - synchronous active-high reset (to RESET_VAL)
//                load       - load load_value this cycle (beats tick)
//                load_value - value to load
//                tick       - decrement by one, sticking at zero
//                value      - current count
//                zero       - high while value == 0
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_down_counter #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             tick,
  output logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;
  logic             zero_q;
  logic             zero_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_value;
    end else if (tick && (value_q != '0)) begin
      value_d = value_q - WIDTH'(1);
    end
    zero_d = (value_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= RESET_VAL;
      zero_q  <= (RESET_VAL == '0);
    end else begin
      value_q <= value_d;
      zero_q  <= zero_d;
    end
  end

  assign value = value_q;
  assign zero  = zero_q;

endmodule
`default_nettype wire

// File: rtl/mario_event_gen.sv
`default_nettype none
// ============================================================================
//  Module      : mario_event_gen
//  Description : Turns raw play-field events (enemy contact, pit fall, flag
//                reached, frame tick) into the sticky over/success levels
//                consumed by state_fsm. Owns the lives counter, the level
//                countdown timer and post-hit invulnerability.
//  Config      : MARIO_EVENT_TIMER_EN - when defined the countdown timer is
//                built and a timeout loses the level; otherwise time_left is
//                tied to 0 and tick only drives invulnerability.
//  Ports       : clk       - system clock
//                rst       - synchronous active-high reset
//                state     - current state_fsm state (mario_pkg encoding)
//                tick      - one-cycle pulse per frame
//                hit       - enemy contact level (rising edge counts)
//                fall      - player below screen
//                goal      - flag reached
//                over      - sticky: level lost
//                success   - sticky: level won
//                lives     - remaining lives
//                time_left - remaining timer ticks
//                invuln    - high while hits are ignored
//  Revision    : 1.0 - initial release
// ============================================================================
module mario_event_gen
  import mario_pkg::*;
#(
  parameter int LIVES_INIT   = DEF_LIVES_INIT,
  parameter int TIME_W       = DEF_TIME_W,
  parameter int TIME_INIT    = DEF_TIME_INIT,
  parameter int INVULN_TICKS = DEF_INVULN_TICKS
) (
  input  logic              clk,
  input  logic              rst,
  input  game_state_t       state,
  input  logic              tick,
  input  logic              hit,
  input  logic              fall,
  input  logic              goal,
  output logic              over,
  output logic              success,
  output logic [1:0]        lives,
  output logic [TIME_W-1:0] time_left,
  output logic              invuln
);

  // Internal FSM encoding.
  localparam logic [1:0] C_FSM_ARMED = 2'd0;
  localparam logic [1:0] C_FSM_RUN   = 2'd1;
  localparam logic [1:0] C_FSM_LOST  = 2'd2;
  localparam logic [1:0] C_FSM_WON   = 2'd3;

  localparam logic [1:0]        C_LIVES_LOAD  = 2'(LIVES_INIT);
  localparam logic [TIME_W-1:0] C_TIME_LOAD   = TIME_W'(TIME_INIT);
  localparam logic [7:0]        C_INVULN_LOAD = 8'(INVULN_TICKS);

  logic [1:0] fsm_q;
  logic [1:0] fsm_d;
  logic       hit_q;
  logic       hit_d;
  logic       over_q;
  logic       over_d;
  logic       success_q;
  logic       success_d;
  logic [1:0] lives_q;
  logic [1:0] lives_d;

  logic       w_play;
  logic       w_hit_edge;
  logic       w_in_run;
  logic       w_live_hit;
  logic       w_fatal_hit;
  logic       w_run_active;
  logic       w_take_hit;
  logic       w_run_tick;
  logic       w_timeout;
  logic       w_reload;
  logic [7:0] w_inv_value;
  logic       w_inv_zero;
  logic       w_timer_unused;
  logic       w_unused;

  // --------------------------------------------------------------------------
  // Event qualification
  // --------------------------------------------------------------------------
  assign w_play     = is_play(state);
  assign w_hit_edge = hit & ~hit_q;

  // RUN with the game still in PLAY; leaving PLAY means an external restart,
  // which overrides every event in that cycle.
  assign w_in_run = (fsm_q == C_FSM_RUN) & w_play;

  // A hit only counts when neither goal nor fall outranks it and the player
  // is not shielded. Shielded edges are simply dropped.
  assign w_live_hit  = w_in_run & ~goal & ~fall & w_hit_edge & ~invuln;
  assign w_fatal_hit = w_live_hit & (lives_q == 2'd1);

  // Lower-priority work (non-fatal hit, tick) happens only when no
  // level-ending event won this cycle.
  assign w_run_active = w_in_run & ~goal & ~fall & ~w_fatal_hit;
  assign w_take_hit   = w_run_active & w_live_hit;
  assign w_run_tick   = w_run_active & tick;

  // Any cycle that lands in ARMED reloads the per-level state, so the
  // cleared values are visible the cycle after IDLE/restart is seen.
  assign w_reload = (fsm_d == C_FSM_ARMED);

  // --------------------------------------------------------------------------
  // Countdown timer
  // --------------------------------------------------------------------------
`ifdef MARIO_EVENT_TIMER_EN
  logic [TIME_W-1:0] w_time_value;
  logic              w_time_zero;

  tick_down_counter #(
    .WIDTH     (TIME_W),
    .RESET_VAL (C_TIME_LOAD)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (w_reload),
    .load_value (C_TIME_LOAD),
    .tick       (w_run_tick),
    .value      (w_time_value),
    .zero       (w_time_zero)
  );

  // The tick that takes the timer from 1 to 0 is the timeout.
  assign w_timeout      = w_run_tick & (w_time_value == TIME_W'(1));
  assign time_left      = w_time_value;
  assign w_timer_unused = w_time_zero;
`else
  assign w_timeout      = 1'b0;
  assign time_left      = '0;
  assign w_timer_unused = |C_TIME_LOAD;
`endif

  // --------------------------------------------------------------------------
  // Invulnerability counter: loaded on a non-fatal hit, run down by ticks.
  // The load beats a same-cycle tick so the full window always applies.
  // --------------------------------------------------------------------------
  tick_down_counter #(
    .WIDTH     (8),
    .RESET_VAL (8'd0)
  ) u_invuln (
    .clk        (clk),
    .rst        (rst),
    .load       (w_reload | w_take_hit),
    .load_value (w_take_hit ? C_INVULN_LOAD : 8'd0),
    .tick       (w_run_tick),
    .value      (w_inv_value),
    .zero       (w_inv_zero)
  );

  assign w_unused = ^{w_inv_value, w_timer_unused};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= C_FSM_ARMED;
      hit_q     <= 1'b0;
      over_q    <= 1'b0;
      success_q <= 1'b0;
      lives_q   <= C_LIVES_LOAD;
    end else begin
      fsm_q     <= fsm_d;
      hit_q     <= hit_d;
      over_q    <= over_d;
      success_q <= success_d;
      lives_q   <= lives_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      C_FSM_ARMED: begin
        if (w_play) begin
          fsm_d = C_FSM_RUN;
        end
      end
      C_FSM_RUN: begin
        if (!w_play) begin
          fsm_d = C_FSM_ARMED;
        end else if (goal) begin
          fsm_d = C_FSM_WON;
        end else if (fall || w_fatal_hit || w_timeout) begin
          fsm_d = C_FSM_LOST;
        end
      end
      C_FSM_LOST, C_FSM_WON: begin
        if (state == ST_IDLE) begin
          fsm_d = C_FSM_ARMED;
        end
      end
      default: fsm_d = C_FSM_ARMED;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    hit_d     = hit;
    over_d    = over_q;
    success_d = success_q;
    lives_d   = lives_q;
    if (w_reload) begin
      over_d    = 1'b0;
      success_d = 1'b0;
      lives_d   = C_LIVES_LOAD;
    end else if (w_in_run) begin
      // goal is checked first so success and over can never both rise.
      if (goal) begin
        success_d = 1'b1;
      end else if (fall || w_fatal_hit || w_timeout) begin
        over_d = 1'b1;
      end
      // lives_q is at least 1 in RUN, so this never wraps.
      if (w_live_hit) begin
        lives_d = lives_q - 2'd1;
      end
    end
  end

  assign over    = over_q;
  assign success = success_q;
  assign lives   = lives_q;
  assign invuln  = ~w_inv_zero;

endmodule
`default_nettype wire

// File: doc/mario_event_gen.md
# mario_event_gen

Upstream stage of `state_fsm`: turns raw play-field events (enemy contact, pit fall, flag reached, frame tick) into the sticky `over`/`success` levels that `state_fsm` consumes. It owns the lives counter, the level countdown timer and post-hit invulnerability. It watches `state` from `state_fsm` to arm, run and clear itself.

## Interface
Parameters:
- `LIVES_INIT`, 3: lives loaded at level start; legal range 1..3.
- `TIME_W`, 9: width of the countdown timer.
- `TIME_INIT`, 300: timer load value in ticks; nonzero, fits `TIME_W`.
- `INVULN_TICKS`, 60: invulnerability length after a hit, in ticks; 1..255.

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: synchronous, active-high reset.
- `state` in 2: current `state_fsm` state; encoding comes from the package.
- `tick` in 1: one-cycle pulse per game frame.
- `hit` in 1: enemy-contact level; only its rising edge counts.
- `fall` in 1: player-below-screen level.
- `goal` in 1: flag-reached level.
- `over` out 1: sticky level to `state_fsm`; the level is lost.
- `success` out 1: sticky level to `state_fsm`; the level is won.
- `lives` out 2: remaining lives.
- `time_left` out `TIME_W`: remaining ticks.
- `invuln` out 1: high while a hit is ignored.

## Operation
State encoding in the package: `ST_IDLE`=2'b00, `ST_PLAY`=2'b01, `ST_OVER`=2'b10, `ST_WIN`=2'b11.

Internal FSM has four states:
- **ARMED**
  - Outputs `over`=0, `success`=0, `invuln`=0.
  - `lives`=`LIVES_INIT`, `time_left`=`TIME_INIT`.
  - Goes to RUN on the first cycle with `state`==`ST_PLAY`.
- **RUN**
  - Evaluates events each cycle, in strict priority order:
    1. `goal`: go to WON and set `success`.
    2. `fall`: go to LOST and set `over`.
    3. Hit edge while `invuln`=0:
       - `lives` decrements.
       - If `lives` was 1, `lives` becomes 0, FSM goes to LOST and `over` is set.
       - Otherwise the invuln counter loads `INVULN_TICKS` and `invuln` is set.
    4. `tick`: `time_left` decrements. If `time_left` reaches 0, go to LOST and set `over`.
  - The invuln counter decrements on `tick`. When it reaches 0, `invuln` clears.
  - A hit edge while `invuln`=1 is discarded and is not queued.
  - If `state` leaves `ST_PLAY` while in RUN (external restart), go to ARMED.
- **LOST / WON**
  - Outputs hold. All events are ignored.
  - Go to ARMED when `state`==`ST_IDLE`.
- **Mutual exclusion:** `over` and `success` are never high together. Once either is set, the other cannot be set until the FSM returns to ARMED.
- **Hit edge definition:** `hit` & ~`hit_q`. `hit_q` is a register, reset to 0, and it updates every cycle in every state.
- **Arithmetic:** counters are unsigned. `lives` never wraps below 0. `time_left` saturates at 0.

## Timing
- **Reset values:**
  - `over`=0, `success`=0, `invuln`=0.
  - `lives`=`LIVES_INIT`, `time_left`=`TIME_INIT`.
  - FSM=ARMED, `hit_q`=0.
- **Outputs:** all registered. The event in cycle N is visible on the outputs in cycle N+1.
- **Clearing:** `state`==`ST_IDLE` sampled in cycle N gives cleared outputs and reloaded counters in cycle N+1.
- **Same-cycle events:**
  - `goal` together with a fatal hit, `fall` or timeout: `success` wins.
  - `tick` together with a non-fatal hit: both counters update in the same cycle.
- **Reset mid-RUN:** returns to reset values at the next edge, regardless of `state`.

## Configuration
- `MARIO_EVENT_TIMER_EN` defined: the countdown timer is present and timeout sets `over`.
- Macro undefined:
  - No timer register is built.
  - `time_left` is tied to 0.
  - Timeout never fires; `tick` only drives invulnerability.

## Structure
- **`mario_pkg`:** holds the `ST_*` localparams, a 2-bit `game_state_t` typedef and the default `LIVES_INIT`/`TIME_INIT` constants. Shared with `state_fsm`.
- **Sub-module `tick_down_counter`:** loadable, tick-enabled, saturating down-counter with `load`, `value` and `zero` ports. It is instantiated for the timer and for invulnerability.

## Test plan
- **Timeout:** `TIME_INIT`=5. Hold `state`=`ST_PLAY` and give 5 ticks → `time_left` reads 4,3,2,1,0; `over`=1 the cycle after the 5th tick; `success` stays 0.
- **Hits to death:** 3 hit pulses spaced by more than `INVULN_TICKS` ticks → `lives` reads 2, 1, 0; `over`=1 together with `lives`=0.
- **Invulnerability:** `hit` pulse, then a second `hit` pulse 10 ticks later with `INVULN_TICKS`=60 → `lives` drops 3→2 only; `invuln` clears 60 ticks after the first hit.
- **Held hit:** `hit` held high for 200 cycles, no ticks → exactly one decrement.
- **Priority:** `goal`=1 and `fall`=1 in the same cycle → `success`=1, `over`=0. Then `state`=`ST_IDLE` → next cycle `success`=0, `lives`=3, `time_left`=`TIME_INIT`.
- **Reset/restart:** `rst` pulsed mid-RUN with `lives`=1 → all outputs return to reset values next cycle. `state` forced `ST_PLAY`→`ST_IDLE` mid-RUN → FSM re-arms and events are ignored while IDLE.
